// File: rtl/mul_final_add.sv
// Final carry-propagate adder of the M-extension multiplier: two-stage split add
// (low half, then high half plus carry) with valid/ready handshakes on both sides.
module mul_final_add #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [2*XLEN-1:0]   sum_i,
    input  logic [2*XLEN-1:0]   carry_i,
    input  logic [1:0]          op_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [XLEN-1:0]     result_o,
    output logic [TAG_W-1:0]    tag_o
);

    // Handshake: a transfer happens on a posedge where valid and ready are both 1;
    // valid must not depend on ready, and data holds while valid=1 and ready=0.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ST_B  = 2'b01,
        ST_A  = 2'b10,
        ST_AB = 2'b11
    } pipe_state_e;

    pipe_state_e state;

    logic              a_vld_q, a_vld_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              c_q, c_d;
    logic [XLEN-1:0]   sum_hi_q, sum_hi_d;
    logic [XLEN-1:0]   carry_hi_q, carry_hi_d;
    logic [1:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_a_q, tag_a_d;

    logic              b_vld_q, b_vld_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_b_q, tag_b_d;

    logic              b_adv;
    logic              accept;
    logic [XLEN:0]     lo_sum;
    logic [XLEN-1:0]   hi_sum;

    assign state = pipe_state_e'({a_vld_q, b_vld_q});

    always_comb begin
        b_adv = 1'b0;
        case (state)
            EMPTY:   b_adv = 1'b0;
            ST_A:    b_adv = 1'b1;
            ST_B:    b_adv = 1'b0;
            ST_AB:   b_adv = ready_i;
            default: b_adv = 1'b0;
        endcase
    end

    assign ready_o = ~rst & ~flush_i & (~a_vld_q | b_adv);
    assign accept  = valid_i & ready_o;

    // Carry out of the top half is intentionally dropped: product is mod 2^(2*XLEN).
    assign lo_sum = {1'b0, sum_i[XLEN-1:0]} + {1'b0, carry_i[XLEN-1:0]};
    assign hi_sum = sum_hi_q + carry_hi_q + {{(XLEN-1){1'b0}}, c_q};

    always_comb begin
        a_vld_d    = a_vld_q;
        lo_d       = lo_q;
        c_d        = c_q;
        sum_hi_d   = sum_hi_q;
        carry_hi_d = carry_hi_q;
        op_d       = op_q;
        tag_a_d    = tag_a_q;
        b_vld_d    = b_vld_q;
        result_d   = result_q;
        tag_b_d    = tag_b_q;

        if (accept) begin
            lo_d       = lo_sum[XLEN-1:0];
            c_d        = lo_sum[XLEN];
            sum_hi_d   = sum_i[2*XLEN-1:XLEN];
            carry_hi_d = carry_i[2*XLEN-1:XLEN];
            op_d       = op_i;
            tag_a_d    = tag_i;
        end

        if (b_adv) begin
            result_d = (op_q == 2'b00) ? lo_q : hi_sum;
            tag_b_d  = tag_a_q;
        end

        // Flush wins over every handshake event; data regs may keep stale values.
        if (flush_i) begin
            a_vld_d = 1'b0;
            b_vld_d = 1'b0;
        end else begin
            if (accept)      a_vld_d = 1'b1;
            else if (b_adv)  a_vld_d = 1'b0;
            if (b_adv)        b_vld_d = 1'b1;
            else if (ready_i) b_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q    <= 1'b0;
            lo_q       <= '0;
            c_q        <= 1'b0;
            sum_hi_q   <= '0;
            carry_hi_q <= '0;
            op_q       <= 2'b00;
            tag_a_q    <= '0;
            b_vld_q    <= 1'b0;
            result_q   <= '0;
            tag_b_q    <= '0;
        end else begin
            a_vld_q    <= a_vld_d;
            lo_q       <= lo_d;
            c_q        <= c_d;
            sum_hi_q   <= sum_hi_d;
            carry_hi_q <= carry_hi_d;
            op_q       <= op_d;
            tag_a_q    <= tag_a_d;
            b_vld_q    <= b_vld_d;
            result_q   <= result_d;
            tag_b_q    <= tag_b_d;
        end
    end

    assign valid_o  = b_vld_q;
    assign result_o = result_q;
    assign tag_o    = tag_b_q;

endmodule

// File: tb/tb_mul_final_add.sv
// Directed bench for mul_final_add: arithmetic corner vectors, latency,
// backpressure, flush, reset mid-flight and back-to-back throughput.
module tb_mul_final_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] sum_i;
    logic [63:0] carry_i;
    logic [1:0]  op_i;
    logic [4:0]  tag_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  tag_o;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    mul_final_add #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .sum_i(sum_i), .carry_i(carry_i), .op_i(op_i), .tag_i(tag_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] s, input logic [63:0] c,
                         input logic [1:0] op, input logic [4:0] t);
        valid_i = v;
        sum_i   = s;
        carry_i = c;
        op_i    = op;
        tag_i   = t;
        #1;
    endtask

    // Issues one op into an empty pipe with ready_i=1 and samples the output after 1 and 2 edges.
    task automatic run_single(input logic [63:0] s, input logic [63:0] c, input logic [1:0] op,
                              input logic [4:0] t, output logic vo_mid, output logic vo,
                              output logic [31:0] res, output logic [4:0] tg);
        drive(1'b1, s, c, op, t);
        step();
        drive(1'b0, 64'h0, 64'h0, 2'b00, 5'd0);
        vo_mid = valid_o;
        step();
        vo  = valid_o;
        res = result_o;
        tg  = tag_o;
        step();
    endtask

    task automatic scoreboard_sample();
        logic [36:0] e;
        if (valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got tag %0d, expected no output", tag_o);
            end else begin
                e = exp_q.pop_front();
                if ({result_o, tag_o} !== e) begin
                    errors++;
                    $display("FAIL sb_order: got res %0h tag %0d, expected res %0h tag %0d",
                             result_o, tag_o, e[36:5], e[4:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rst_result: got %0h expected 0", result_o); end
        checks++; if (tag_o !== 5'd0) begin errors++; $display("FAIL rst_tag: got %0d expected 0", tag_o); end
        rst = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", ready_o); end
    endtask

    task automatic test_mul();
        logic vm, vo;
        logic [31:0] res;
        logic [4:0] tg;
        ready_i = 1'b1;
        run_single(64'd42, 64'd0, 2'b00, 5'd3, vm, vo, res, tg);
        checks++; if (vm !== 1'b0) begin errors++; $display("FAIL mul_latency: valid after 1 edge got %b expected 0", vm); end
        checks++; if (vo !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b expected 1", vo); end
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_result: got %0h expected 2a", res); end
        checks++; if (tg !== 5'd3) begin errors++; $display("FAIL mul_tag: got %0d expected 3", tg); end
    endtask

    task automatic test_arith();
        logic vm, vo;
        logic [31:0] res;
        logic [4:0] tg;
        ready_i = 1'b1;
        run_single(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b11, 5'd4, vm, vo, res, tg);
        checks++; if (vo !== 1'b1 || res !== 32'h1) begin errors++; $display("FAIL split_mulhu: got v%b %0h expected v1 1", vo, res); end
        run_single(64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 5'd5, vm, vo, res, tg);
        checks++; if (vo !== 1'b1 || res !== 32'h0) begin errors++; $display("FAIL split_mul: got v%b %0h expected v1 0", vo, res); end
        run_single(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b01, 5'd6, vm, vo, res, tg);
        checks++; if (vo !== 1'b1 || res !== 32'h0) begin errors++; $display("FAIL wrap_mulh: got v%b %0h expected v1 0", vo, res); end
        run_single(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 5'd7, vm, vo, res, tg);
        checks++; if (vo !== 1'b1 || res !== 32'h0) begin errors++; $display("FAIL wrap_mul: got v%b %0h expected v1 0", vo, res); end
        run_single(64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, 2'b10, 5'd8, vm, vo, res, tg);
        checks++; if (res !== 32'h1234_5679 || tg !== 5'd8) begin errors++; $display("FAIL mulhsu_plain: got %0h tag %0d expected 12345679 tag 8", res, tg); end
        run_single(64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 2'b10, 5'd9, vm, vo, res, tg);
        checks++; if (res !== 32'h4) begin errors++; $display("FAIL both_carry_hi: got %0h expected 4", res); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        drive(1'b1, 64'd101, 64'd0, 2'b00, 5'd1);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept1: got %b expected 1", ready_o); end
        step();
        drive(1'b1, 64'd102, 64'd0, 2'b00, 5'd2);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept2: got %b expected 1", ready_o); end
        step();
        drive(1'b1, 64'd103, 64'd0, 2'b00, 5'd3);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b expected 0", ready_o); end
        checks++; if (valid_o !== 1'b1 || tag_o !== 5'd1) begin errors++; $display("FAIL bp_first_out: got v%b tag %0d expected v1 tag 1", valid_o, tag_o); end
        step();
        step();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b expected 0", ready_o); end
        checks++; if (valid_o !== 1'b1 || tag_o !== 5'd1 || result_o !== 32'd101) begin
            errors++; $display("FAIL bp_hold: got v%b tag %0d res %0d expected v1 tag 1 res 101", valid_o, tag_o, result_o); end
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ready_o); end
        step();
        drive(1'b0, 64'h0, 64'h0, 2'b00, 5'd0);
        checks++; if (valid_o !== 1'b1 || tag_o !== 5'd2 || result_o !== 32'd102) begin
            errors++; $display("FAIL bp_out2: got v%b tag %0d res %0d expected v1 tag 2 res 102", valid_o, tag_o, result_o); end
        step();
        checks++; if (valid_o !== 1'b1 || tag_o !== 5'd3 || result_o !== 32'd103) begin
            errors++; $display("FAIL bp_out3: got v%b tag %0d res %0d expected v1 tag 3 res 103", valid_o, tag_o, result_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", valid_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1'b1, 64'd110, 64'd0, 2'b00, 5'd10);
        step();
        drive(1'b1, 64'd111, 64'd0, 2'b00, 5'd11);
        step();
        flush_i = 1'b1;
        drive(1'b1, 64'd112, 64'd0, 2'b00, 5'd12);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", ready_o); end
        step();
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, 64'd200, 64'd0, 2'b00, 5'd13);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b expected 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_reaccept: got %b expected 1", ready_o); end
        step();
        drive(1'b0, 64'h0, 64'h0, 2'b00, 5'd0);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_stale: got v%b tag %0d expected v0", valid_o, tag_o); end
        step();
        checks++; if (valid_o !== 1'b1 || tag_o !== 5'd13 || result_o !== 32'd200) begin
            errors++; $display("FAIL flush_new_op: got v%b tag %0d res %0d expected v1 tag 13 res 200", valid_o, tag_o, result_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_after: got v%b tag %0d expected v0", valid_o, tag_o); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        drive(1'b1, 64'd120, 64'd0, 2'b00, 5'd20);
        step();
        drive(1'b1, 64'd121, 64'd0, 2'b00, 5'd21);
        step();
        drive(1'b0, 64'h0, 64'h0, 2'b00, 5'd0);
        checks++; if (valid_o !== 1'b1 || tag_o !== 5'd20) begin errors++; $display("FAIL rmid_inflight: got v%b tag %0d expected v1 tag 20", valid_o, tag_o); end
        rst = 1'b1;
        step();
        checks++; if (valid_o !== 1'b0 || result_o !== 32'h0 || tag_o !== 5'd0) begin
            errors++; $display("FAIL rmid_clear: got v%b res %0h tag %0d expected v0 res 0 tag 0", valid_o, result_o, tag_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b expected 0", ready_o); end
        rst = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b expected 1", ready_o); end
        ready_i = 1'b1;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_no_ghost: got v%b tag %0d expected v0", valid_o, tag_o); end
    endtask

    task automatic test_back_to_back();
        int n_out;
        ready_i = 1'b1;
        exp_q.delete();
        n_out = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 64'(k * 3 + 5), 64'h0000_0007_0000_0000, k[1:0] == 2'b01 ? 2'b11 : 2'b00, 5'(k + 24));
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", k, ready_o); end
            exp_q.push_back({(k[1:0] == 2'b01) ? 32'd7 : 32'(k * 3 + 5), 5'(k + 24)});
            if (valid_o) n_out++;
            scoreboard_sample();
            step();
        end
        drive(1'b0, 64'h0, 64'h0, 2'b00, 5'd0);
        for (int k = 0; k < 6; k++) begin
            if (valid_o) n_out++;
            scoreboard_sample();
            step();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d outputs pending expected 0", exp_q.size()); end
        checks++; if (n_out != 6) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 6", n_out); end
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        valid_i = 1'b0;
        sum_i = '0;
        carry_i = '0;
        op_i = 2'b00;
        tag_i = '0;
        test_reset();
        test_mul();
        test_arith();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
